// File: rtl/exe_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider, 32 cycles per op.
// Optional divider datapath guarded by MULDIV_DIV_EN; when undefined, divide ops complete with md_illegal_op.
module exe_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid_e,
    output logic            issue_ready_e,
    input  logic [2:0]      md_op_e,
    input  logic [XLEN-1:0] md_src1_e,
    input  logic [XLEN-1:0] md_src2_e,
    input  logic [4:0]      md_rd_e,
    input  logic            flush_e,
    input  logic            result_ready_w,
    output logic            md_result_valid,
    output logic [XLEN-1:0] md_result,
    output logic [4:0]      md_rd_out,
    output logic            md_busy,
    output logic            md_illegal_op
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;

    // Operand sign handling at issue: MULH both signed, MULHSU rs1 only, DIV/REM both signed.
    logic            src1_signed, src2_signed, src1_neg, src2_neg;
    logic [XLEN-1:0] src1_mag, src2_mag;

    assign src1_signed = md_op_e[2] ? ~md_op_e[0] : (md_op_e == 3'b001 || md_op_e == 3'b010);
    assign src2_signed = md_op_e[2] ? ~md_op_e[0] : (md_op_e == 3'b001);
    assign src1_neg    = src1_signed & md_src1_e[XLEN-1];
    assign src2_neg    = src2_signed & md_src2_e[XLEN-1];
    assign src1_mag    = src1_neg ? -md_src1_e : md_src1_e;
    assign src2_mag    = src2_neg ? -md_src2_e : md_src2_e;

    // Multiplier step: upper half accumulates, lower half holds the remaining multiplier bits.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc, mul_prod;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    assign mul_acc  = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_prod = neg_q ? -mul_acc : mul_acc;

`ifdef MULDIV_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            rneg_q, rneg_d;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff, div_rem, div_quo, div_qfinal, div_rfinal;

    // Divider step: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign div_shift  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge     = div_shift >= {1'b0, opb_q};
    assign div_diff   = div_shift[XLEN-1:0] - opb_q;
    assign div_rem    = div_ge ? div_diff : div_shift[XLEN-1:0];
    assign div_quo    = {acc_q[XLEN-2:0], div_ge};
    assign div_qfinal = neg_q ? -div_quo : div_quo;
    assign div_rfinal = rneg_q ? -div_rem : div_rem;
`endif

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no path can infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifdef MULDIV_DIV_EN
        rneg_d    = rneg_q;
`endif

        if (flush_e) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_valid_e) begin
                        op_d      = md_op_e;
                        rd_d      = md_rd_e;
                        cnt_d     = 5'd0;
                        illegal_d = 1'b0;
                        acc_d     = {{XLEN{1'b0}}, src1_mag};
                        opb_d     = src2_mag;
                        neg_d     = src1_neg ^ src2_neg;
                        if (!md_op_e[2]) begin
                            state_d = S_MUL;
                        end else begin
`ifdef MULDIV_DIV_EN
                            rneg_d = src1_neg;
                            if (md_src2_e == '0) begin
                                result_d = md_op_e[1] ? md_src1_e : {XLEN{1'b1}};
                                state_d  = S_DONE;
                            end else if (src1_signed && md_src1_e == INT_MIN && md_src2_e == {XLEN{1'b1}}) begin
                                result_d = md_op_e[1] ? {XLEN{1'b0}} : INT_MIN;
                                state_d  = S_DONE;
                            end else begin
                                state_d = S_DIV;
                            end
`else
                            result_d  = '0;
                            illegal_d = 1'b1;
                            state_d   = S_DONE;
`endif
                        end
                    end
                end
                S_MUL: begin
                    acc_d = mul_acc;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = (op_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
                        state_d  = S_DONE;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    acc_d = {div_rem, div_quo};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_d = op_q[1] ? div_rfinal : div_qfinal;
                        state_d  = S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (result_ready_w) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifdef MULDIV_DIV_EN
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign issue_ready_e   = (state_q == S_IDLE);
    assign md_busy         = (state_q != S_IDLE);
    assign md_result_valid = (state_q == S_DONE);
    assign md_result       = result_q;
    assign md_rd_out       = rd_q;
    assign md_illegal_op   = illegal_q & md_result_valid;

endmodule

// File: doc/exe_muldiv_seq.md
# exe_muldiv_seq

Multi-cycle multiply/divide sequencer for the execute stage of the RISC-V core. It sits beside the single-cycle ALU and takes RV32M ops from the execute stage with a valid/ready handshake. It runs an iterative shift-add multiplier or restoring divider over 32 cycles, stalls the pipeline while busy, and holds the result until writeback accepts it.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid_e  in  1  execute stage presents an M op.
- issue_ready_e  out  1  sequencer can accept an op; high only in IDLE.
- md_op_e  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- md_src1_e  in  32  rs1 operand.
- md_src2_e  in  32  rs2 operand.
- md_rd_e  in  5  destination register tag.
- flush_e  in  1  kill the in-flight op (branch taken or trap).
- result_ready_w  in  1  writeback accepts the result.
- md_result_valid  out  1  md_result and md_rd_out are valid.
- md_result  out  32  result.
- md_rd_out  out  5  destination tag of the result.
- md_busy  out  1  stall request to the pipeline; high in any state other than IDLE.
- md_illegal_op  out  1  qualified by md_result_valid; see Configuration.

Clock is clk. Reset is rst, synchronous and active-high.

## Operation
States are IDLE, MUL, DIV and DONE.

**IDLE**
- issue_ready_e=1.
- On issue_valid_e & ~flush_e the block:
  - latches the op, rd and operand magnitudes;
  - records the sign-correction flags: MULH treats both operands as signed, MULHSU treats only rs1 as signed, DIV/REM are signed;
  - clears the iteration counter (5-bit, counts 0..31);
  - goes to MUL if md_op_e[2]=0, otherwise to DIV.
- Divide special cases go straight to DONE with no iteration:
  - src2==0: quotient 0xFFFFFFFF, remainder = src1.
  - Signed overflow (src1=0x80000000, src2=0xFFFFFFFF, signed op): quotient 0x80000000, remainder 0.

**MUL**
- Each cycle, if multiplier LSB=1, add the multiplicand into the upper half of a 64-bit accumulator, then shift right by 1.
- After the 32nd iteration (counter==31) go to DONE. On that transition apply two's-complement negation of the 64-bit product when the sign flags differ.
- Result selection: MUL takes bits [31:0]; MULH, MULHSU and MULHU take bits [63:32].

**DIV**
- Restoring division on magnitudes, one quotient bit per cycle:
  - remainder = {remainder, dividend MSB};
  - subtract the divisor if remainder >= divisor.
- After 32 iterations go to DONE. On that transition:
  - negate the quotient if the operand signs differ;
  - give the remainder the sign of the dividend.
- Result selection: DIV/DIVU take the quotient; REM/REMU take the remainder.

**DONE**
- md_result_valid=1; md_result and md_rd_out are held stable.
- On result_ready_w, go to IDLE.

**General rules**
- flush_e in any state: next state IDLE, md_result_valid cleared, no result delivered. Flush takes priority over result_ready_w and over issue_valid_e.
- All arithmetic is unsigned on magnitudes plus the recorded sign flags. Counter wrap is not used, because the transition out of MUL/DIV occurs at counter==31.

## Timing
- Reset: state IDLE, counter 0, accumulators 0. Outputs on reset:
  - issue_ready_e=1;
  - md_busy=0, md_result_valid=0, md_illegal_op=0;
  - md_result=0, md_rd_out=0.
- Normal op latency:
  - accept edge E0;
  - iterations on edges E1..E32;
  - md_result_valid high from the cycle after E32, i.e. 32 cycles after E0.
- Special-case divides: md_result_valid high the cycle after E0.
- Handshake: the result transfers on the edge where md_result_valid & result_ready_w.
  - The next accept is possible no earlier than the following edge, because issue_ready_e is low in DONE.
  - Minimum issue-to-issue spacing is 34 cycles for normal ops.
- md_busy is registered; it is high from the cycle after E0 through the DONE handshake edge.
- rst mid-operation: identical to reset values on the next edge. Any partial result is discarded.

## Configuration
Macro: MULDIV_DIV_EN.
- **Defined:** the divider datapath and DIV state are present. All eight ops are supported as described above.
- **Undefined:** the divider logic is compiled out.
  - Ops with md_op_e[2]=1 are accepted and go directly to DONE the cycle after E0.
  - The result is md_result=0 and md_illegal_op=1.
  - MUL ops are unaffected.

## Test plan
- Reset, then idle: issue_ready_e=1, md_busy=0, md_result_valid=0, md_result=0.
- MUL 0x00000007 × 0xFFFFFFFD: md_result=0xFFFFFFEB, valid 32 cycles after accept. MULH with the same operands gives 0xFFFFFFFF; MULHU gives 0x00000006.
- DIV 0xFFFFFFF9 (−7) / 2: quotient 0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF. DIVU 100/7 gives 14; REMU 100/7 gives 2.
- Divide special cases: DIVU x/0 gives 0xFFFFFFFF; REM 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000. Each is valid 1 cycle after accept.
- Backpressure and flush:
  - hold result_ready_w=0 for 10 cycles; the result stays stable and issue_ready_e stays 0;
  - assert flush_e in MUL cycle 15; the block returns to IDLE and no valid is seen.
- MULDIV_DIV_EN undefined: DIV 10/2 gives md_illegal_op=1 and md_result=0; MUL 3×4 still gives 12.
